// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the HI/LO multiply/divide sequencer.
// Optional build macro: MULDIV_EARLY_OUT_EN (divide early-out, used in muldiv_ctrl).
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam int          DIV_ITERS_DEF = 32;
  localparam int          CNT_W         = 6;
  localparam logic [31:0] DIV0_LO       = 32'hFFFF_FFFF;

  // Two's-complement negate when en is set, pass-through otherwise.
  function automatic logic [31:0] neg32(input logic [31:0] v, input logic en);
    logic [31:0] r;
    if (en) begin
      r = ~v + 32'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    return neg32(v, is_signed & v[31]);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_div_step.sv
// One restoring-divide iteration: shift {rem,quo} left by one, trial-subtract
// the divisor and keep the difference, setting the quotient bit, if it stays non-negative.
module div_step (
  input  logic [31:0] rem,
  input  logic [31:0] quo,
  input  logic [31:0] divisor,
  output logic [31:0] rem_next,
  output logic [31:0] quo_next
);

  logic [32:0] part_s;
  logic [32:0] diff_s;

  assign part_s = {rem, quo[31]};
  assign diff_s = part_s - {1'b0, divisor};

  // A borrow out of the 33-bit subtract means the trial went negative.
  always_comb begin
    if (diff_s[32]) begin
      rem_next = part_s[31:0];
      quo_next = {quo[30:0], 1'b0};
    end else begin
      rem_next = diff_s[31:0];
      quo_next = {quo[30:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer for the EX stage: fixed-latency multiply and
// 1-bit/cycle restoring divide. Define MULDIV_EARLY_OUT_EN to skip divides where |rt| > |rs|.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT   = 2,
  parameter int DIV_ITERS = DIV_ITERS_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  input  logic        hilo_read_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        stall_o,
  output logic        done_o,
  output logic [63:0] result_o,
  output logic        hi_write_o,
  output logic        lo_write_o
);

  state_e            state_r, state_nxt_s, start_tgt_s;
  logic              busy_r, done_r, busy_nxt_s, done_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [63:0]       prod_r, prod_s, result_r;
  logic [31:0]       rem_r, quo_r, divisor_r;
  logic [31:0]       rs_abs_s, rt_abs_s, step_rem_s, step_quo_s, fix_hi_s, fix_lo_s;
  logic              neg_quo_r, neg_rem_r, div0_r;
  logic              accept_s, is_div_s, is_sdiv_s, is_smul_s, early_s, last_mul_s, last_div_s;

  assign is_div_s   = op_i[1];
  assign is_sdiv_s  = (op_i == OP_DIV);
  assign is_smul_s  = (op_i == OP_MULT);
  assign accept_s   = start_i & ~flush_i & ((state_r == ST_IDLE) | (state_r == ST_DONE));
  assign rs_abs_s   = abs32(rs_i, is_sdiv_s);
  assign rt_abs_s   = abs32(rt_i, is_sdiv_s);
  assign prod_s     = {{32{is_smul_s & rs_i[31]}}, rs_i} * {{32{is_smul_s & rt_i[31]}}, rt_i};
  assign last_mul_s = (cnt_r == CNT_W'(MUL_LAT - 1));
  assign last_div_s = (cnt_r == CNT_W'(DIV_ITERS - 1));

`ifdef MULDIV_EARLY_OUT_EN
  assign early_s = is_div_s & (rt_abs_s > rs_abs_s) & (rt_i != 32'd0);
`else
  assign early_s = 1'b0;
`endif

  div_step u_div_step (
    .rem      (rem_r),
    .quo      (quo_r),
    .divisor  (divisor_r),
    .rem_next (step_rem_s),
    .quo_next (step_quo_s)
  );

  // Entry state for a newly accepted op.
  always_comb begin
    if (!is_div_s) begin
      start_tgt_s = ST_MUL;
    end else if (early_s) begin
      start_tgt_s = ST_FIX;
    end else begin
      start_tgt_s = ST_DIV;
    end
  end

  // Next-state logic; flush aborts any busy state, DONE can chain straight into a new op.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: state_nxt_s = accept_s ? start_tgt_s : ST_IDLE;
      ST_MUL:  state_nxt_s = flush_i ? ST_IDLE : (last_mul_s ? ST_DONE : ST_MUL);
      ST_DIV:  state_nxt_s = flush_i ? ST_IDLE : (last_div_s ? ST_FIX : ST_DIV);
      ST_FIX:  state_nxt_s = flush_i ? ST_IDLE : ST_DONE;
      ST_DONE: state_nxt_s = accept_s ? start_tgt_s : ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode from the next state so busy/done come straight off flops.
  always_comb begin
    busy_nxt_s = 1'b0;
    done_nxt_s = 1'b0;
    case (state_nxt_s)
      ST_MUL, ST_DIV, ST_FIX: busy_nxt_s = 1'b1;
      ST_DONE:                done_nxt_s = 1'b1;
      default: begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
      end
    endcase
  end

  // State register with registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  // Sign fix-up; a signed divide by zero still reports all-ones in LO.
  always_comb begin
    fix_hi_s = neg32(rem_r, neg_rem_r);
    if (div0_r) begin
      fix_lo_s = DIV0_LO;
    end else begin
      fix_lo_s = neg32(quo_r, neg_quo_r);
    end
  end

  // Operand capture at accept and per-cycle divide iteration / latency count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r     <= {CNT_W{1'b0}};
      prod_r    <= 64'd0;
      rem_r     <= 32'd0;
      quo_r     <= 32'd0;
      divisor_r <= 32'd0;
      neg_quo_r <= 1'b0;
      neg_rem_r <= 1'b0;
      div0_r    <= 1'b0;
    end else if (accept_s) begin
      cnt_r     <= {CNT_W{1'b0}};
      prod_r    <= prod_s;
      rem_r     <= early_s ? rs_abs_s : 32'd0;
      quo_r     <= early_s ? 32'd0 : rs_abs_s;
      divisor_r <= rt_abs_s;
      neg_quo_r <= is_sdiv_s & (rs_i[31] ^ rt_i[31]);
      neg_rem_r <= is_sdiv_s & rs_i[31];
      div0_r    <= (rt_i == 32'd0);
    end else if (state_r == ST_DIV) begin
      rem_r <= step_rem_s;
      quo_r <= step_quo_s;
      cnt_r <= cnt_r + CNT_W'(1);
    end else if (state_r == ST_MUL) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Result register loads only on entry to DONE, so it holds across flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r <= 64'd0;
    end else if ((state_r == ST_MUL) && (state_nxt_s == ST_DONE)) begin
      result_r <= prod_r;
    end else if ((state_r == ST_FIX) && (state_nxt_s == ST_DONE)) begin
      result_r <= {fix_hi_s, fix_lo_s};
    end
  end

  assign busy_o     = busy_r;
  assign done_o     = done_r;
  assign hi_write_o = done_r;
  assign lo_write_o = done_r;
  assign result_o   = result_r;
  assign stall_o    = (start_i | hilo_read_i) & busy_r & ~flush_i;

endmodule
